// File: rtl/issue_control.sv
// Issue controller: scoreboard-based hazard check between decode and execute,
// with fetch hold across control flow and write drain ahead of halt.
module issue_control #(
  parameter int NUM_SREGS   = 32,
  parameter int NUM_PREGS   = 8,
  parameter int STALL_CNT_W = 16,
  parameter int REG_SEL     = $clog2(NUM_SREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inst_valid,
  output logic                   inst_ready,
  input  logic                   is_branch,
  input  logic                   is_call,
  input  logic                   is_ret,
  input  logic                   halted,
  input  logic                   a_regbank_sel,
  input  logic                   a_from_regbank,
  input  logic [REG_SEL-1:0]     a_regbank_addr,
  input  logic                   b_regbank_sel,
  input  logic                   b_from_regbank,
  input  logic [REG_SEL-1:0]     b_regbank_addr,
  input  logic                   z_regbank_sel,
  input  logic [REG_SEL-1:0]     z_regbank_addr,
  input  logic                   ex_ready,
  output logic                   issue_valid,
  input  logic                   wb_valid,
  input  logic                   wb_regbank_sel,
  input  logic [REG_SEL-1:0]     wb_regbank_addr,
  input  logic                   br_resolved,
  output logic                   fetch_hold,
  output logic                   core_halted,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int   PSEL_W = $clog2(NUM_PREGS);
  localparam logic S_REGS = 1'b0;
  localparam logic P_REGS = 1'b1;

  typedef enum logic [1:0] {RUN = 2'd0, BR_WAIT = 2'd1, DRAIN = 2'd2, HALTED = 2'd3} state_t;

  state_t                 state_q, state_d;
  logic [NUM_SREGS-1:0]   s_busy_q, s_busy_d;
  logic [NUM_PREGS-1:0]   p_busy_q, p_busy_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic writes_z, is_ctrl, hazard, sb_clear, sb_clear_next, fire;

  function automatic logic busy_of(input logic                 sel,
                                   input logic [REG_SEL-1:0]   addr,
                                   input logic [NUM_SREGS-1:0] s_bits,
                                   input logic [NUM_PREGS-1:0] p_bits);
    if (sel == P_REGS) return p_bits[addr[PSEL_W-1:0]];
    return s_bits[addr];
  endfunction

  assign writes_z = !(is_branch || is_ret || halted);
  assign is_ctrl  = is_branch || is_call || is_ret;
  assign sb_clear = (~|s_busy_q) && (~|p_busy_q);

  // Hazards look only at registered busy bits; a same-cycle write-back is not bypassed.
  assign hazard = (a_from_regbank && busy_of(a_regbank_sel, a_regbank_addr, s_busy_q, p_busy_q))
               || (b_from_regbank && busy_of(b_regbank_sel, b_regbank_addr, s_busy_q, p_busy_q))
               || (writes_z       && busy_of(z_regbank_sel, z_regbank_addr, s_busy_q, p_busy_q));

  assign fire = (state_q == RUN) && inst_valid && ex_ready && !hazard && (!halted || sb_clear);

  // Clear from write-back first, then set from issue, so a collision leaves the bit set.
  always_comb begin
    s_busy_d = s_busy_q;
    p_busy_d = p_busy_q;
    if (wb_valid) begin
      if (wb_regbank_sel == P_REGS) p_busy_d[wb_regbank_addr[PSEL_W-1:0]] = 1'b0;
      else                          s_busy_d[wb_regbank_addr]             = 1'b0;
    end
    if (fire && writes_z) begin
      if (z_regbank_sel == P_REGS) p_busy_d[z_regbank_addr[PSEL_W-1:0]] = 1'b1;
      else                         s_busy_d[z_regbank_addr]             = 1'b1;
    end
  end

  assign sb_clear_next = (~|s_busy_d) && (~|p_busy_d);

  always_comb begin
    stall_d = stall_q;
    if (inst_valid && !fire && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      s_busy_q <= '0;
      p_busy_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      s_busy_q <= s_busy_d;
      p_busy_q <= p_busy_d;
      stall_q  <= stall_d;
    end
  end

  // DRAIN leaves as soon as the post-write-back scoreboard is empty, so HALT issues the next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (fire && is_ctrl)                          state_d = BR_WAIT;
        else if (fire && halted)                      state_d = HALTED;
        else if (inst_valid && halted && !sb_clear)   state_d = DRAIN;
      end
      BR_WAIT: if (br_resolved)   state_d = RUN;
      DRAIN:   if (sb_clear_next) state_d = RUN;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    inst_ready   = fire;
    issue_valid  = fire;
    fetch_hold   = (state_q != RUN) || (fire && (is_ctrl || halted));
    core_halted  = (state_q == HALTED);
    stall_cycles = stall_q;
  end

endmodule

// File: tb/tb_issue_control.sv
// Bench for issue_control: vector table through a scoreboard queue, plus
// hand-written halt-drain and asynchronous-reset sequences.
module tb_issue_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        inst_valid, inst_ready, is_branch, is_call, is_ret, halted;
  logic        a_regbank_sel, a_from_regbank, b_regbank_sel, b_from_regbank, z_regbank_sel;
  logic [4:0]  a_regbank_addr, b_regbank_addr, z_regbank_addr, wb_regbank_addr;
  logic        ex_ready, issue_valid, wb_valid, wb_regbank_sel, br_resolved;
  logic        fetch_hold, core_halted;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  issue_control dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .is_branch(is_branch), .is_call(is_call), .is_ret(is_ret), .halted(halted),
    .a_regbank_sel(a_regbank_sel), .a_from_regbank(a_from_regbank), .a_regbank_addr(a_regbank_addr),
    .b_regbank_sel(b_regbank_sel), .b_from_regbank(b_from_regbank), .b_regbank_addr(b_regbank_addr),
    .z_regbank_sel(z_regbank_sel), .z_regbank_addr(z_regbank_addr),
    .ex_ready(ex_ready), .issue_valid(issue_valid),
    .wb_valid(wb_valid), .wb_regbank_sel(wb_regbank_sel), .wb_regbank_addr(wb_regbank_addr),
    .br_resolved(br_resolved), .fetch_hold(fetch_hold), .core_halted(core_halted),
    .stall_cycles(stall_cycles)
  );

  typedef struct {
    string      name;
    logic       iv;
    logic [3:0] fl;
    logic       a_f, a_s; logic [4:0] a_a;
    logic       b_f, b_s; logic [4:0] b_a;
    logic       z_s;      logic [4:0] z_a;
    logic       exr, wbv, wbs; logic [4:0] wba;
    logic       brr;
    logic       er, eh;
  } vec_t;

  typedef struct {
    string name;
    logic  iv;
    logic  rdy;
    logic  hold;
  } exp_t;

  vec_t  tbl[$];
  exp_t  sbq[$];
  int    n_pass = 0;
  int    n_total = 0;
  logic [15:0] exp_stall = '0;

  function automatic vec_t idle(string nm);
    vec_t v;
    v.name = nm; v.iv = 1'b0; v.fl = 4'b0;
    v.a_f = 1'b0; v.a_s = 1'b0; v.a_a = '0;
    v.b_f = 1'b0; v.b_s = 1'b0; v.b_a = '0;
    v.z_s = 1'b0; v.z_a = '0;
    v.exr = 1'b1; v.wbv = 1'b0; v.wbs = 1'b0; v.wba = '0; v.brr = 1'b0;
    v.er = 1'b0; v.eh = 1'b0;
    return v;
  endfunction

  // fl = {branch, call, ret, halt}; bank 0 = S, 1 = P
  function automatic vec_t ins(string nm, logic [3:0] fl, logic af, logic as_, int aa,
                               logic bf, logic bs, int ba, logic zs, int za);
    vec_t v;
    v = idle(nm);
    v.iv = 1'b1; v.fl = fl;
    v.a_f = af; v.a_s = as_; v.a_a = 5'(aa);
    v.b_f = bf; v.b_s = bs;  v.b_a = 5'(ba);
    v.z_s = zs; v.z_a = 5'(za);
    return v;
  endfunction

  function automatic vec_t wbk(vec_t v, logic s, int a);
    vec_t r;
    r = v; r.wbv = 1'b1; r.wbs = s; r.wba = 5'(a);
    return r;
  endfunction

  function automatic vec_t res(vec_t v);
    vec_t r;
    r = v; r.brr = 1'b1;
    return r;
  endfunction

  function automatic vec_t noex(vec_t v);
    vec_t r;
    r = v; r.exr = 1'b0;
    return r;
  endfunction

  task automatic add(vec_t v, logic r, logic h);
    vec_t t;
    t = v; t.er = r; t.eh = h;
    tbl.push_back(t);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
  endtask

  task automatic set_inputs(vec_t v);
    inst_valid = v.iv;
    {is_branch, is_call, is_ret, halted} = v.fl;
    a_from_regbank = v.a_f; a_regbank_sel = v.a_s; a_regbank_addr = v.a_a;
    b_from_regbank = v.b_f; b_regbank_sel = v.b_s; b_regbank_addr = v.b_a;
    z_regbank_sel = v.z_s; z_regbank_addr = v.z_a;
    ex_ready = v.exr;
    wb_valid = v.wbv; wb_regbank_sel = v.wbs; wb_regbank_addr = v.wba;
    br_resolved = v.brr;
  endtask

  task automatic drive(vec_t v);
    exp_t e;
    set_inputs(v);
    e.name = v.name; e.iv = v.iv; e.rdy = v.er; e.hold = v.eh;
    sbq.push_back(e);
  endtask

  // Compare combinational outputs mid-cycle, then the stall counter after the edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      @(posedge clk); #1;
      return;
    end
    e = sbq.pop_front();
    chk({e.name, "/inst_ready"},  inst_ready,  e.rdy);
    chk({e.name, "/issue_valid"}, issue_valid, e.rdy);
    chk({e.name, "/fetch_hold"},  fetch_hold,  e.hold);
    @(posedge clk); #1;
    if (e.iv && !e.rdy && (exp_stall != 16'hFFFF)) exp_stall = exp_stall + 16'd1;
    chk({e.name, "/stall_cycles"}, stall_cycles, exp_stall);
  endtask

  task automatic apply(vec_t v, logic r, logic h);
    vec_t t;
    t = v; t.er = r; t.eh = h;
    drive(t);
    cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_stall = '0;
  endtask

  vec_t sub, br, sub2, waw, call, t, hlt, dep;

  initial begin
    set_inputs(idle("init"));
    #1 rst_n = 1'b0;

    // Reset state: combinational outputs follow inst_valid && ex_ready
    set_inputs(ins("rst_probe", 4'b0000, 1, 0, 5, 0, 0, 0, 0, 6));
    #2;
    chk("rst/inst_ready",   inst_ready,   1);
    chk("rst/issue_valid",  issue_valid,  1);
    chk("rst/fetch_hold",   fetch_hold,   0);
    chk("rst/core_halted",  core_halted,  0);
    chk("rst/stall_cycles", stall_cycles, 0);
    set_inputs(idle("idle"));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // RAW stall on S5
    add(ins("add_s5", 4'b0000, 1, 0, 1, 1, 0, 2, 0, 5), 1, 0);
    sub = ins("sub_raw_s5", 4'b0000, 1, 0, 5, 1, 0, 3, 0, 6);
    add(sub, 0, 0); add(sub, 0, 0); add(sub, 0, 0);
    add(wbk(sub, 0, 5), 0, 0);
    add(sub, 1, 0);
    // Bank separation: P3 busy does not block S3
    add(wbk(ins("cmp_p3", 4'b0000, 1, 0, 1, 1, 0, 2, 1, 3), 0, 6), 1, 0);
    add(ins("add_rd_s3", 4'b0000, 1, 0, 3, 1, 0, 4, 0, 7), 1, 0);
    br = ins("br_rd_p3", 4'b1000, 1, 1, 3, 0, 0, 0, 0, 0);
    add(wbk(br, 0, 7), 0, 0);
    add(wbk(br, 1, 3), 0, 0);
    add(br, 1, 1);
    // Branch hold until resolve; the instruction alongside br_resolved waits a cycle
    add(idle("br_wait1"), 0, 1);
    add(idle("br_wait2"), 0, 1);
    t = ins("add_s8", 4'b0000, 1, 0, 1, 1, 0, 2, 0, 8);
    add(res(t), 0, 1);
    add(t, 1, 0);
    // Set/clear collision on S9
    add(wbk(ins("add_s9_wb_s9", 4'b0000, 1, 0, 1, 1, 0, 2, 0, 9), 0, 9), 1, 0);
    sub2 = ins("sub_rd_s9", 4'b0000, 1, 0, 9, 0, 0, 0, 0, 10);
    add(wbk(sub2, 0, 8), 0, 0);
    add(wbk(sub2, 0, 9), 0, 0);
    add(sub2, 1, 0);
    // WAW on S10, then ex_ready low
    waw = ins("waw_s10", 4'b0000, 1, 0, 1, 1, 0, 2, 0, 10);
    add(waw, 0, 0);
    add(wbk(waw, 0, 10), 0, 0);
    add(noex(waw), 0, 0);
    add(waw, 1, 0);
    // RET ignores busy Z; CALL does check it
    add(ins("ret", 4'b0010, 0, 0, 0, 0, 0, 0, 0, 10), 1, 1);
    add(res(idle("ret_resolve")), 0, 1);
    call = ins("call_z_s10", 4'b0100, 0, 0, 0, 0, 0, 0, 0, 10);
    add(call, 0, 0);
    add(wbk(call, 0, 10), 0, 0);
    add(call, 1, 1);
    add(wbk(res(idle("call_resolve")), 0, 10), 0, 1);
    add(res(idle("stray_resolve")), 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      cycle();
    end

    // Halt drain: HALT waits in DRAIN for S7's write-back
    apply(ins("add_s7", 4'b0000, 1, 0, 1, 1, 0, 2, 0, 7), 1, 0);
    hlt = ins("halt", 4'b0001, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(hlt, 0, 0);
    apply(hlt, 0, 1);
    apply(wbk(hlt, 0, 7), 0, 1);
    chk("drain/core_halted_before", core_halted, 0);
    apply(hlt, 1, 1);
    chk("halt/core_halted", core_halted, 1);
    apply(ins("after_halt", 4'b0000, 1, 0, 1, 1, 0, 2, 0, 12), 0, 1);
    chk("halt/core_halted_stays", core_halted, 1);

    do_reset();
    chk("reset2/core_halted", core_halted, 0);

    // Async reset from BR_WAIT with S1..S3 busy and a saturated stall counter
    apply(ins("add_s1", 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1), 1, 0);
    apply(ins("add_s2", 4'b0000, 0, 0, 0, 0, 0, 0, 0, 2), 1, 0);
    apply(ins("add_s3", 4'b0000, 0, 0, 0, 0, 0, 0, 0, 3), 1, 0);
    apply(ins("br_plain", 4'b1000, 0, 0, 0, 0, 0, 0, 0, 0), 1, 1);
    dep = ins("dep_s1", 4'b0000, 1, 0, 1, 0, 0, 0, 0, 4);
    set_inputs(dep);
    repeat (65540) @(posedge clk);
    #1;
    chk("sat/stall_cycles", stall_cycles, 16'hFFFF);
    chk("sat/fetch_hold",   fetch_hold,   1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst/stall_cycles", stall_cycles, 0);
    chk("async_rst/fetch_hold",   fetch_hold,   0);
    chk("async_rst/core_halted",  core_halted,  0);
    chk("async_rst/inst_ready",   inst_ready,   1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_stall = '0;
    apply(ins("indep_after_rst", 4'b0000, 0, 0, 0, 0, 0, 0, 0, 20), 1, 0);
    apply(dep, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/issue_control.md
# issue_control

Issue controller between the decoder and the execute stage. Each cycle it takes one decoded instruction and checks it against a register scoreboard covering the scalar (S) and predicate (P) banks. It issues the instruction only when there is no hazard and execute is ready. It also holds fetch after control-flow instructions until execute resolves them, and drains outstanding writes before entering the halted state.

## Interface
Parameters:
- `NUM_SREGS`, 32: scalar registers tracked; one scoreboard bit each, indexed by `REG_SEL`-bit address.
- `NUM_PREGS`, 8: predicate registers tracked; indexed by address bits [2:0].
- `STALL_CNT_W`, 16: width of the saturating stall counter.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inst_valid`  in  1  decoded instruction present.
- `inst_ready`  out  1  instruction accepted this cycle (fire).
- `is_branch`, `is_call`, `is_ret`, `halted`  in  1 each  decoder flags.
- `a_regbank_sel`, `a_from_regbank`  in  1 each  operand A bank and "A reads a register".
- `a_regbank_addr`  in  `REG_SEL`  operand A register.
- `b_regbank_sel`, `b_from_regbank`  in  1 each  operand B bank and "B reads a register".
- `b_regbank_addr`  in  `REG_SEL`  operand B register.
- `z_regbank_sel`  in  1  destination bank.
- `z_regbank_addr`  in  `REG_SEL`  destination register.
- `ex_ready`  in  1  execute can accept an instruction.
- `issue_valid`  out  1  instruction handed to execute; equals `inst_ready`.
- `wb_valid`  in  1  a write-back completes this cycle.
- `wb_regbank_sel`  in  1  write-back bank.
- `wb_regbank_addr`  in  `REG_SEL`  write-back register.
- `br_resolved`  in  1  execute has resolved the pending branch, call or ret (single-cycle pulse).
- `fetch_hold`  out  1  fetch must stop supplying new instructions.
- `core_halted`  out  1  core is halted.
- `stall_cycles`  out  `STALL_CNT_W`  count of cycles with `inst_valid` high and no fire (saturating).

## Operation
- Derived signals:
  - `writes_z = !(is_branch || is_ret || halted)`.
  - `is_ctrl = is_branch || is_call || is_ret`.
- Scoreboard: a busy bit per S register and per P register. Bank is selected by `*_regbank_sel` (`S_REGS`/`P_REGS`).
- Hazard is any of the following:
  - `a_from_regbank` and A's busy bit is set;
  - `b_from_regbank` and B's busy bit is set;
  - `writes_z` and Z's busy bit is set (WAW).
- Hazard checks use the registered scoreboard only. A write-back in the same cycle does not bypass the check; the instruction issues one cycle later.
- Fire = state RUN, `inst_valid`, `ex_ready`, no hazard.
  - For `halted`, fire additionally requires the scoreboard to be entirely clear.
- On fire with `writes_z`: set Z's busy bit.
- On `wb_valid`: clear the addressed busy bit.
  - If the same bit is set and cleared in one cycle, set wins.
- State machine, 2-bit:
  - RUN: fire with `is_ctrl` goes to BR_WAIT. Fire with `halted` goes to HALTED. `halted` pending while the scoreboard is not clear goes to DRAIN.
  - BR_WAIT: no fire. `br_resolved` goes to RUN.
  - DRAIN: no fire. Scoreboard clear goes to RUN, where the HALT then fires.
  - HALTED: terminal until `rst_n` is asserted. Write-backs still clear bits.
- `br_resolved` outside BR_WAIT is ignored.
- `fetch_hold` = (state != RUN) or (fire with `is_ctrl` or `halted`).
- `stall_cycles` increments when `inst_valid && !inst_ready`, including in BR_WAIT and DRAIN, and saturates at all ones.

## Timing
- Issue has zero-cycle latency: `inst_ready`/`issue_valid` are combinational from inputs and registered state.
- A scoreboard bit set by a fire is visible to the hazard check on the next cycle. Back-to-back dependent instructions therefore stall until write-back, plus one cycle.
- `core_halted` is registered and goes high on the edge after the HALT fires.
- Reset values: state RUN, all busy bits 0, `stall_cycles` 0, `core_halted` 0.
  - Combinational outputs under reset: `fetch_hold` 0, `inst_ready` = `issue_valid` = `inst_valid && ex_ready` (scoreboard clear).
- Reset mid-operation immediately discards BR_WAIT, DRAIN or HALTED and all busy bits.
- Simultaneous `br_resolved` and a new instruction: the transition to RUN takes effect next cycle; the instruction fires no earlier than that cycle.
- Write-back to a register that is not busy: no effect, no error.

## Test plan
- RAW stall:
  - Stimulus: ADD writing S5 fires at cycle 0; SUB reading S5 is presented at cycle 1; `wb_valid` for S5 arrives at cycle 4.
  - Required: SUB fires at cycle 5, and `stall_cycles` = 4.
- Bank separation: CMP writing P3, then ADD reading S3 → ADD fires the next cycle. A branch reading P3 stalls until write-back to P3.
- Branch hold:
  - Stimulus: BR fires; `br_resolved` arrives 3 cycles later.
  - Required: `fetch_hold` is 1 from the fire cycle through the resolve cycle; the next instruction fires no earlier than the cycle after resolve.
- Halt drain:
  - Stimulus: HALT presented while S7 is busy; write-back to S7 at cycle 2.
  - Required: DRAIN, then RUN at cycle 3, HALT fires at cycle 3, `core_halted` = 1 at cycle 4, `inst_ready` = 0 from then on.
- Set/clear collision: fire writing S9 in the same cycle as write-back to S9 → S9 remains busy.
- Async reset: assert `rst_n` = 0 mid-BR_WAIT with 3 busy bits and `stall_cycles` = 0xFFFF → all state cleared immediately without a clock edge. After release, an independent instruction fires in the first cycle.
